axi_write_arbiter: RTL and testbench

//  Shares one AXI write path (AW/W/B) to a slave port between two write masters M0 and M1.

---
 rtl/axi_warb_pkg.sv | 21 ++
 rtl/axi_write_arbiter_rr.sv | 22 ++
 rtl/axi_write_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_warb_pkg.sv
// Shared types and constants for the two-master AXI write arbiter.
package axi_warb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } warb_state_e;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  localparam int unsigned TAG_BITS = 4;
  localparam logic [TAG_BITS-1:0] M0_TAG_DEF = 4'b0001;
  localparam logic [TAG_BITS-1:0] M1_TAG_DEF = 4'b0010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axi_warb_pkg

// File: rtl/axi_write_arbiter_rr.sv
// Two-way round-robin arbiter: a tie goes to the master not granted last.
module axi_rr_arbiter2
  import axi_warb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_any
);

  always_comb begin
    o_any   = |i_req;
    o_grant = GRANT_M0;
    case (i_req)
      2'b01:   o_grant = GRANT_M0;
      2'b10:   o_grant = GRANT_M1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = GRANT_M0;
    endcase
  end

endmodule : axi_rr_arbiter2

// File: rtl/axi_write_arbiter.sv
// Shares one AXI write path between masters M0/M1; one transaction in flight.
// Optional B-wait timeout with SLVERR completion: define AXI_WARB_TIMEOUT_EN.
module axi_write_arbiter
  import axi_warb_pkg::*;
#(
  parameter int unsigned         AXI_ID_BITS    = 4,
  parameter int unsigned         AXI_ADDR_BITS  = 32,
  parameter int unsigned         AXI_LEN_BITS   = 8,
  parameter int unsigned         AXI_SIZE_BITS  = 3,
  parameter int unsigned         AXI_DATA_BITS  = 32,
  parameter int unsigned         AXI_STRB_BITS  = AXI_DATA_BITS / 8,
  parameter logic [TAG_BITS-1:0] M0_TAG         = M0_TAG_DEF,
  parameter logic [TAG_BITS-1:0] M1_TAG         = M1_TAG_DEF,
  parameter int unsigned         TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  // master 0
  input  logic [AXI_ID_BITS-1:0]            AWID_M0,
  input  logic [AXI_ADDR_BITS-1:0]          AWADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]           AWLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0]          AWSIZE_M0,
  input  logic [1:0]                        AWBURST_M0,
  input  logic                              AWVALID_M0,
  output logic                              AWREADY_M0,
  input  logic [AXI_DATA_BITS-1:0]          WDATA_M0,
  input  logic [AXI_STRB_BITS-1:0]          WSTRB_M0,
  input  logic                              WLAST_M0,
  input  logic                              WVALID_M0,
  output logic                              WREADY_M0,
  output logic [AXI_ID_BITS-1:0]            BID_M0,
  output logic [1:0]                        BRESP_M0,
  output logic                              BVALID_M0,
  input  logic                              BREADY_M0,
  // master 1
  input  logic [AXI_ID_BITS-1:0]            AWID_M1,
  input  logic [AXI_ADDR_BITS-1:0]          AWADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]           AWLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0]          AWSIZE_M1,
  input  logic [1:0]                        AWBURST_M1,
  input  logic                              AWVALID_M1,
  output logic                              AWREADY_M1,
  input  logic [AXI_DATA_BITS-1:0]          WDATA_M1,
  input  logic [AXI_STRB_BITS-1:0]          WSTRB_M1,
  input  logic                              WLAST_M1,
  input  logic                              WVALID_M1,
  output logic                              WREADY_M1,
  output logic [AXI_ID_BITS-1:0]            BID_M1,
  output logic [1:0]                        BRESP_M1,
  output logic                              BVALID_M1,
  input  logic                              BREADY_M1,
  // slave
  output logic [AXI_ID_BITS+TAG_BITS-1:0]   AWID_S,
  output logic [AXI_ADDR_BITS-1:0]          AWADDR_S,
  output logic [AXI_LEN_BITS-1:0]           AWLEN_S,
  output logic [AXI_SIZE_BITS-1:0]          AWSIZE_S,
  output logic [1:0]                        AWBURST_S,
  output logic                              AWVALID_S,
  input  logic                              AWREADY_S,
  output logic [AXI_DATA_BITS-1:0]          WDATA_S,
  output logic [AXI_STRB_BITS-1:0]          WSTRB_S,
  output logic                              WLAST_S,
  output logic                              WVALID_S,
  input  logic                              WREADY_S,
  input  logic [AXI_ID_BITS+TAG_BITS-1:0]   BID_S,
  input  logic [1:0]                        BRESP_S,
  input  logic                              BVALID_S,
  output logic                              BREADY_S
);

  warb_state_e r_state, w_state_next;
  logic        r_grant, r_last_grant;
  logic        w_arb_grant, w_arb_any;

  logic [AXI_ID_BITS-1:0]   w_sel_awid;
  logic [AXI_ADDR_BITS-1:0] w_sel_awaddr;
  logic [AXI_LEN_BITS-1:0]  w_sel_awlen;
  logic [AXI_SIZE_BITS-1:0] w_sel_awsize;
  logic [1:0]               w_sel_awburst;
  logic                     w_sel_awvalid;
  logic [AXI_DATA_BITS-1:0] w_sel_wdata;
  logic [AXI_STRB_BITS-1:0] w_sel_wstrb;
  logic                     w_sel_wlast;
  logic                     w_sel_wvalid;
  logic                     w_sel_bready;
  logic [TAG_BITS-1:0]      w_sel_tag;

  logic                     w_aw_hs, w_w_done, w_b_hs;
  logic                     w_awready_g, w_wready_g, w_bvalid_g;
  logic [AXI_ID_BITS-1:0]   w_bid_g;
  logic [1:0]               w_bresp_g;
  logic                     w_unused_bid_tag;

  assign w_unused_bid_tag = ^BID_S[AXI_ID_BITS+TAG_BITS-1:AXI_ID_BITS];

  axi_rr_arbiter2 u_rr (
    .i_req        ({AWVALID_M1, AWVALID_M0}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_any        (w_arb_any)
  );

  assign w_sel_awid    = (r_grant == GRANT_M1) ? AWID_M1    : AWID_M0;
  assign w_sel_awaddr  = (r_grant == GRANT_M1) ? AWADDR_M1  : AWADDR_M0;
  assign w_sel_awlen   = (r_grant == GRANT_M1) ? AWLEN_M1   : AWLEN_M0;
  assign w_sel_awsize  = (r_grant == GRANT_M1) ? AWSIZE_M1  : AWSIZE_M0;
  assign w_sel_awburst = (r_grant == GRANT_M1) ? AWBURST_M1 : AWBURST_M0;
  assign w_sel_awvalid = (r_grant == GRANT_M1) ? AWVALID_M1 : AWVALID_M0;
  assign w_sel_wdata   = (r_grant == GRANT_M1) ? WDATA_M1   : WDATA_M0;
  assign w_sel_wstrb   = (r_grant == GRANT_M1) ? WSTRB_M1   : WSTRB_M0;
  assign w_sel_wlast   = (r_grant == GRANT_M1) ? WLAST_M1   : WLAST_M0;
  assign w_sel_wvalid  = (r_grant == GRANT_M1) ? WVALID_M1  : WVALID_M0;
  assign w_sel_bready  = (r_grant == GRANT_M1) ? BREADY_M1  : BREADY_M0;
  assign w_sel_tag     = (r_grant == GRANT_M1) ? M1_TAG     : M0_TAG;

  assign w_aw_hs  = (r_state == AW) & w_sel_awvalid & AWREADY_S;
  assign w_w_done = (r_state == W) & w_sel_wvalid & WREADY_S & w_sel_wlast;

`ifdef AXI_WARB_TIMEOUT_EN
  localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_BITS-1:0]     r_to_cnt;
  logic [AXI_ID_BITS-1:0] r_awid;
  logic                   w_to;

  // Counter saturates at the limit, so w_to stays set until the master takes B.
  assign w_to   = (r_state == B) && (r_to_cnt == TO_BITS'(TIMEOUT_CYCLES));
  assign w_b_hs = (r_state == B) & (w_to ? w_sel_bready : (BVALID_S & w_sel_bready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_awid   <= '0;
    end else begin
      if (w_aw_hs) r_awid <= w_sel_awid;
      if (w_w_done) r_to_cnt <= '0;
      else if ((r_state == B) && !BVALID_S && !w_to) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_b_hs = (r_state == B) & BVALID_S & w_sel_bready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= GRANT_M0;
      r_last_grant <= GRANT_M1;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && w_arb_any) r_grant <= w_arb_grant;
      if (w_b_hs) r_last_grant <= r_grant;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_state_next = AW;
      AW:      if (w_aw_hs)   w_state_next = W;
      W:       if (w_w_done)  w_state_next = B;
      B:       if (w_b_hs)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    AWID_S      = '0;
    AWADDR_S    = '0;
    AWLEN_S     = '0;
    AWSIZE_S    = '0;
    AWBURST_S   = '0;
    AWVALID_S   = 1'b0;
    WDATA_S     = '0;
    WSTRB_S     = '0;
    WLAST_S     = 1'b0;
    WVALID_S    = 1'b0;
    BREADY_S    = 1'b0;
    w_awready_g = 1'b0;
    w_wready_g  = 1'b0;
    w_bvalid_g  = 1'b0;
    w_bid_g     = '0;
    w_bresp_g   = '0;
    case (r_state)
      AW: begin
        AWID_S      = {w_sel_tag, w_sel_awid};
        AWADDR_S    = w_sel_awaddr;
        AWLEN_S     = w_sel_awlen;
        AWSIZE_S    = w_sel_awsize;
        AWBURST_S   = w_sel_awburst;
        AWVALID_S   = w_sel_awvalid;
        w_awready_g = AWREADY_S;
      end
      W: begin
        WDATA_S    = w_sel_wdata;
        WSTRB_S    = w_sel_wstrb;
        WLAST_S    = w_sel_wlast;
        WVALID_S   = w_sel_wvalid;
        w_wready_g = WREADY_S;
      end
      B: begin
`ifdef AXI_WARB_TIMEOUT_EN
        if (w_to) begin
          w_bvalid_g = 1'b1;
          w_bresp_g  = RESP_SLVERR;
          w_bid_g    = r_awid;
        end else begin
          w_bvalid_g = BVALID_S;
          w_bresp_g  = BRESP_S;
          w_bid_g    = BID_S[AXI_ID_BITS-1:0];
          BREADY_S   = w_sel_bready;
        end
`else
        w_bvalid_g = BVALID_S;
        w_bresp_g  = BRESP_S;
        w_bid_g    = BID_S[AXI_ID_BITS-1:0];
        BREADY_S   = w_sel_bready;
`endif
      end
      default: ;
    endcase
  end

  // Master-side returns: only the granted master ever sees non-zero values.
  always_comb begin
    AWREADY_M0 = 1'b0;
    WREADY_M0  = 1'b0;
    BVALID_M0  = 1'b0;
    BID_M0     = '0;
    BRESP_M0   = '0;
    AWREADY_M1 = 1'b0;
    WREADY_M1  = 1'b0;
    BVALID_M1  = 1'b0;
    BID_M1     = '0;
    BRESP_M1   = '0;
    if (r_grant == GRANT_M1) begin
      AWREADY_M1 = w_awready_g;
      WREADY_M1  = w_wready_g;
      BVALID_M1  = w_bvalid_g;
      BID_M1     = w_bid_g;
      BRESP_M1   = w_bresp_g;
    end else begin
      AWREADY_M0 = w_awready_g;
      WREADY_M0  = w_wready_g;
      BVALID_M0  = w_bvalid_g;
      BID_M0     = w_bid_g;
      BRESP_M0   = w_bresp_g;
    end
  end

endmodule : axi_write_arbiter

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter.
module tb_axi_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  AWID_M0, AWID_M1, BID_M0, BID_M1;
  logic [31:0] AWADDR_M0, AWADDR_M1, WDATA_M0, WDATA_M1;
  logic [7:0]  AWLEN_M0, AWLEN_M1;
  logic [2:0]  AWSIZE_M0, AWSIZE_M1;
  logic [1:0]  AWBURST_M0, AWBURST_M1, BRESP_M0, BRESP_M1;
  logic [3:0]  WSTRB_M0, WSTRB_M1;
  logic        AWVALID_M0, AWVALID_M1, AWREADY_M0, AWREADY_M1;
  logic        WLAST_M0, WLAST_M1, WVALID_M0, WVALID_M1, WREADY_M0, WREADY_M1;
  logic        BVALID_M0, BVALID_M1, BREADY_M0, BREADY_M1;
  logic [7:0]  AWID_S, BID_S;
  logic [31:0] AWADDR_S, WDATA_S;
  logic [7:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S, BRESP_S;
  logic [3:0]  WSTRB_S;
  logic        AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  cur_id   [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_data [2];

  axi_write_arbiter dut (
    .clk(clk), .rst(rst),
    .AWID_M0(AWID_M0), .AWADDR_M0(AWADDR_M0), .AWLEN_M0(AWLEN_M0), .AWSIZE_M0(AWSIZE_M0),
    .AWBURST_M0(AWBURST_M0), .AWVALID_M0(AWVALID_M0), .AWREADY_M0(AWREADY_M0),
    .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WLAST_M0(WLAST_M0), .WVALID_M0(WVALID_M0),
    .WREADY_M0(WREADY_M0), .BID_M0(BID_M0), .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0),
    .BREADY_M0(BREADY_M0),
    .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWSIZE_M1(AWSIZE_M1),
    .AWBURST_M1(AWBURST_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1), .WVALID_M1(WVALID_M1),
    .WREADY_M1(WREADY_M1), .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1),
    .BREADY_M1(BREADY_M1),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] tag_of(input int m);
    return (m == 1) ? 4'b0010 : 4'b0001;
  endfunction
  function automatic logic awready_of(input int m);
    return (m == 1) ? AWREADY_M1 : AWREADY_M0;
  endfunction
  function automatic logic wready_of(input int m);
    return (m == 1) ? WREADY_M1 : WREADY_M0;
  endfunction
  function automatic logic bvalid_of(input int m);
    return (m == 1) ? BVALID_M1 : BVALID_M0;
  endfunction
  function automatic logic [5:0] b_of(input int m);
    return (m == 1) ? {BID_M1, BRESP_M1} : {BID_M0, BRESP_M0};
  endfunction

  task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [31:0] data);
    cur_id[m] = id; cur_addr[m] = addr; cur_data[m] = data;
    if (m == 0) begin
      AWID_M0 = id; AWADDR_M0 = addr; AWLEN_M0 = 8'd0; AWSIZE_M0 = 3'd2; AWBURST_M0 = 2'b01;
      WDATA_M0 = data; WSTRB_M0 = 4'hF; WLAST_M0 = 1'b1; AWVALID_M0 = 1'b1; WVALID_M0 = 1'b1;
    end else begin
      AWID_M1 = id; AWADDR_M1 = addr; AWLEN_M1 = 8'd0; AWSIZE_M1 = 3'd2; AWBURST_M1 = 2'b01;
      WDATA_M1 = data; WSTRB_M1 = 4'hF; WLAST_M1 = 1'b1; AWVALID_M1 = 1'b1; WVALID_M1 = 1'b1;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) begin AWVALID_M0 = 1'b0; WVALID_M0 = 1'b0; end
    else        begin AWVALID_M1 = 1'b0; WVALID_M1 = 1'b0; end
  endtask

  task automatic set_bready(input int m, input logic v);
    if (m == 0) BREADY_M0 = v; else BREADY_M1 = v;
  endtask

  task automatic chk_aw(input int m);
    check_eq("aw_valid_s", AWVALID_S, 1'b1);
    check_eq("aw_id_s",    AWID_S, {tag_of(m), cur_id[m]});
    check_eq("aw_addr_s",  AWADDR_S, cur_addr[m]);
    check_eq("aw_attr_s",  {AWLEN_S, AWSIZE_S, AWBURST_S}, {8'd0, 3'd2, 2'b01});
    check_eq("aw_early_w", {WVALID_S, WREADY_M1, WREADY_M0}, 3'b000);
  endtask

  task automatic chk_w(input int m);
    check_eq("w_valid_s", WVALID_S, 1'b1);
    check_eq("w_data_s",  WDATA_S, cur_data[m]);
    check_eq("w_strb_last_s", {WSTRB_S, WLAST_S}, {4'hF, 1'b1});
    check_eq("w_no_aw",   AWVALID_S, 1'b0);
  endtask

  // Entered at a negedge in IDLE with the request(s) already driven.
  task automatic aw_phase(input int m, input int aw_wait);
    #1;
    check_eq("idle_awvalid_s", AWVALID_S, 1'b0);
    check_eq("idle_readys", {AWREADY_M1, AWREADY_M0, WREADY_M1, WREADY_M0}, 4'b0);
    @(negedge clk);
    AWREADY_S = 1'b0;
    for (int i = 0; i < aw_wait; i++) begin
      #1; chk_aw(m);
      check_eq("aw_stall_ready", awready_of(m), 1'b0);
      @(negedge clk);
    end
    AWREADY_S = 1'b1;
    #1; chk_aw(m);
    check_eq("aw_ready_g", awready_of(m), 1'b1);
    check_eq("aw_ready_other", awready_of(1 - m), 1'b0);
    @(negedge clk);
    AWREADY_S = 1'b0;
    if (m == 0) AWVALID_M0 = 1'b0; else AWVALID_M1 = 1'b0;
  endtask

  task automatic w_phase(input int m, input int w_wait);
    for (int i = 0; i < w_wait; i++) begin
      #1; chk_w(m);
      check_eq("w_stall_ready", wready_of(m), 1'b0);
      @(negedge clk);
    end
    WREADY_S = 1'b1;
    #1; chk_w(m);
    check_eq("w_ready_g", wready_of(m), 1'b1);
    check_eq("w_ready_other", wready_of(1 - m), 1'b0);
    @(negedge clk);
    WREADY_S = 1'b0;
    drop_req(m);
  endtask

  task automatic b_phase(input int m, input int b_wait, input logic [1:0] resp);
    BVALID_S = 1'b1; BID_S = {tag_of(m), cur_id[m]}; BRESP_S = resp;
    set_bready(m, 1'b0);
    for (int i = 0; i < b_wait; i++) begin
      #1;
      check_eq("b_hold_valid", bvalid_of(m), 1'b1);
      check_eq("b_hold_id_resp", b_of(m), {cur_id[m], resp});
      check_eq("b_hold_bready_s", BREADY_S, 1'b0);
      @(negedge clk);
    end
    set_bready(m, 1'b1);
    #1;
    check_eq("b_valid_g", bvalid_of(m), 1'b1);
    check_eq("b_id_resp_g", b_of(m), {cur_id[m], resp});
    check_eq("b_bready_s", BREADY_S, 1'b1);
    check_eq("b_other", {bvalid_of(1 - m), b_of(1 - m)}, 7'd0);
    @(negedge clk);
    BVALID_S = 1'b0; BID_S = '0; BRESP_S = '0;
    set_bready(m, 1'b0);
    #1;
    check_eq("b_done_valid", bvalid_of(m), 1'b0);
    check_eq("b_done_idle_aw", AWVALID_S, 1'b0);
  endtask

  task automatic run_txn(input int m, input int aw_w, input int w_w, input int b_w,
                         input logic [1:0] resp);
    aw_phase(m, aw_w);
    w_phase(m, w_w);
    b_phase(m, b_w, resp);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    {AWID_M0, AWADDR_M0, AWLEN_M0, AWSIZE_M0, AWBURST_M0, AWVALID_M0} = '0;
    {WDATA_M0, WSTRB_M0, WLAST_M0, WVALID_M0, BREADY_M0} = '0;
    {AWID_M1, AWADDR_M1, AWLEN_M1, AWSIZE_M1, AWBURST_M1, AWVALID_M1} = '0;
    {WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1, BREADY_M1} = '0;
    {AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S} = '0;

    // Reset state, with requests and slave responses already active.
    @(negedge clk);
    set_req(0, 4'h5, 32'h100, 32'hDEADBEEF);
    AWREADY_S = 1'b1; WREADY_S = 1'b1; BVALID_S = 1'b1; BREADY_M0 = 1'b1;
    #1;
    check_eq("rst_aw_s", {AWVALID_S, AWID_S, AWADDR_S}, 41'd0);
    check_eq("rst_w_s", {WVALID_S, WDATA_S, WLAST_S}, 34'd0);
    check_eq("rst_readys", {AWREADY_M0, WREADY_M0, BVALID_M0, BREADY_S}, 4'd0);
    @(negedge clk);
    {AWREADY_S, WREADY_S, BVALID_S, BREADY_M0} = '0;
    rst = 1'b1;

    // Single M0 write; M1 must stay quiet throughout.
    run_txn(0, 0, 0, 0, 2'b00);

    // Simultaneous requests after reset alternate strictly, M0 first.
    apply_reset();
    set_req(0, 4'h0, 32'h2000, 32'hA0000000);
    set_req(1, 4'h8, 32'h3000, 32'hB0000000);
    for (int k = 0; k < 20; k++) begin
      int m;
      m = k % 2;
      run_txn(m, 0, 0, 0, 2'b00);
      if (k < 18)
        set_req(m, 4'((k + 2) & 15), 32'h2000 + 32'(k * 4), 32'hC0000000 + 32'(k));
    end

    // SLVERR from slave with master BREADY held off four cycles.
    set_req(1, 4'h9, 32'h400, 32'h12345678);
    run_txn(1, 0, 0, 4, 2'b10);

    // Slave back-pressure on AW and W.
    set_req(0, 4'h3, 32'h500, 32'h0BADF00D);
    run_txn(0, 5, 3, 0, 2'b00);

    // Reset while M1 is in W: async clear, no completion, M0 wins the next tie.
    set_req(1, 4'hA, 32'h600, 32'h55AA55AA);
    aw_phase(1, 0);
    #1;
    check_eq("w_before_rst", WVALID_S, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_w_s", {WVALID_S, WDATA_S, WREADY_M1}, 34'd0);
    check_eq("arst_misc", {AWVALID_S, AWID_S, BREADY_S, BVALID_M0, BVALID_M1}, 12'd0);
    drop_req(1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("post_rst_no_b", {BVALID_M0, BVALID_M1}, 2'b00);
    set_req(0, 4'h6, 32'h700, 32'h01020304);
    set_req(1, 4'hB, 32'h800, 32'h05060708);
    run_txn(0, 0, 0, 0, 2'b00);
    run_txn(1, 0, 0, 0, 2'b00);

`ifdef AXI_WARB_TIMEOUT_EN
    // Slave never answers B: SLVERR with the original id after 16 B cycles.
    set_req(0, 4'hC, 32'h900, 32'hFEEDFACE);
    aw_phase(0, 0);
    w_phase(0, 0);
    BREADY_M0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("to_wait_bvalid", BVALID_M0, 1'b0);
      @(negedge clk);
    end
    #1;
    check_eq("to_bvalid", BVALID_M0, 1'b1);
    check_eq("to_id_resp", {BID_M0, BRESP_M0}, {4'hC, 2'b10});
    check_eq("to_bready_s", BREADY_S, 1'b0);
    BREADY_M0 = 1'b1;
    @(negedge clk);
    BREADY_M0 = 1'b0;
    #1;
    check_eq("to_done", BVALID_M0, 1'b0);
    set_req(1, 4'h1, 32'hA00, 32'h11111111);
    run_txn(1, 0, 0, 0, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axi_write_arbiter
